// File: rtl/runner_game_if.sv
// Signal bundle between the runner game sequencer and its neighbours (buttons, collision, renderer).
// master = the sequencer (drives tick/state/jump_y/score_bcd/run_en/game_over);
// slave = input/renderer side (drives btn_jump/collide). RUNNER_PAUSE_EN adds btn_pause/paused.
interface runner_game_if;
  logic        btn_jump;
  logic        collide;
  logic        tick;
  logic [2:0]  state;
  logic [4:0]  jump_y;
  logic [15:0] score_bcd;
  logic        run_en;
  logic        game_over;
`ifdef RUNNER_PAUSE_EN
  logic        btn_pause;
  logic        paused;

  modport master (
    input  btn_jump, collide, btn_pause,
    output tick, state, jump_y, score_bcd, run_en, game_over, paused
  );
  modport slave (
    output btn_jump, collide, btn_pause,
    input  tick, state, jump_y, score_bcd, run_en, game_over, paused
  );
`else
  modport master (
    input  btn_jump, collide,
    output tick, state, jump_y, score_bcd, run_en, game_over
  );
  modport slave (
    output btn_jump, collide,
    input  tick, state, jump_y, score_bcd, run_en, game_over
  );
`endif
endinterface

// File: rtl/runner_game_ctrl.sv
// Runner game sequencer: frame-tick prescaler, IDLE/RUN/UP/DOWN/DEAD FSM, jump height and BCD score.
// Latency: all outputs registered; state/run_en/game_over change one clk after the causing input.
// Backpressure: none, free-running; inputs are levels sampled every clk. Optional pause: RUNNER_PAUSE_EN.
// Ports: clk, reset (async, active-high), gif (runner_game_if.master): btn_jump, collide in;
//        tick, state[2:0], jump_y[4:0], score_bcd[15:0], run_en, game_over out (+btn_pause/paused).
module runner_game_ctrl #(
  parameter int TICK_DIV  = 1666666,
  parameter int JUMP_H    = 12,
  parameter int SCORE_DIV = 6
) (
  input  logic          clk,
  input  logic          reset,
  runner_game_if.master gif
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int SW = (SCORE_DIV > 1) ? $clog2(SCORE_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SUB_LAST  = SW'(SCORE_DIV - 1);
  localparam logic [4:0]    JY_LAST   = 5'(JUMP_H - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RUN  = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DEAD = 3'd4
  } state_t;

  state_t        st, st_nxt;
  logic [PW-1:0] pcnt, pcnt_nxt;
  logic          tick_r;
  logic          btn_q;
  logic          jmp;
  logic [4:0]    jump_y, jy_nxt;
  logic [15:0]   score, sc_nxt;
  logic [SW-1:0] sub, sub_nxt;
  logic          run_en_r, game_over_r;
  logic          frozen;
  logic          paused_nxt;

  function automatic logic is_active(input state_t s);
    return (s == S_RUN) || (s == S_UP) || (s == S_DOWN);
  endfunction

  // BCD +1 across four digits, sticking at 9999 instead of wrapping.
  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = 1'b1;
    if (s == 16'h9999) return s;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign jmp      = gif.btn_jump & ~btn_q;
  assign pcnt_nxt = (pcnt == TICK_LAST) ? '0 : pcnt + 1'b1;

`ifdef RUNNER_PAUSE_EN
  logic pause_q;
  logic paused_r;
  logic pedge;

  assign pedge  = gif.btn_pause & ~pause_q;
  assign frozen = paused_r;

  // The flag only lives while a game is in progress; any exit to IDLE/DEAD drops it.
  always_comb begin
    paused_nxt = paused_r;
    if (is_active(st) && pedge) paused_nxt = ~paused_r;
    if (!is_active(st_nxt))     paused_nxt = 1'b0;
  end

  assign gif.paused = paused_r;
`else
  assign frozen     = 1'b0;
  assign paused_nxt = 1'b0;
`endif

  always_comb begin
    st_nxt  = st;
    jy_nxt  = jump_y;
    sc_nxt  = score;
    sub_nxt = sub;
    if (is_active(st)) begin
      if (!frozen) begin
        // Collision wins over the tick and the jump edge: nothing else moves that cycle.
        if (gif.collide) begin
          st_nxt = S_DEAD;
        end else begin
          if (tick_r) begin
            if (sub == SUB_LAST) begin
              sub_nxt = '0;
              sc_nxt  = bcd_inc(score);
            end else begin
              sub_nxt = sub + 1'b1;
            end
          end
          if (st == S_RUN) begin
            if (jmp) st_nxt = S_UP;
          end else if (st == S_UP) begin
            if (tick_r) begin
              jy_nxt = jump_y + 5'd1;
              if (jump_y == JY_LAST) st_nxt = S_DOWN;
            end
          end else begin
            if (tick_r) begin
              jy_nxt = jump_y - 5'd1;
              if (jump_y == 5'd1) st_nxt = S_RUN;
            end
          end
        end
      end
    end else if (st == S_DEAD) begin
      if (jmp) st_nxt = S_IDLE;
    end else begin
      // IDLE (and any stray code) starts a fresh game on the jump edge.
      if (jmp) begin
        st_nxt  = S_RUN;
        jy_nxt  = '0;
        sc_nxt  = '0;
        sub_nxt = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= S_IDLE;
      pcnt        <= '0;
      tick_r      <= 1'b0;
      btn_q       <= 1'b0;
      jump_y      <= '0;
      score       <= '0;
      sub         <= '0;
      run_en_r    <= 1'b0;
      game_over_r <= 1'b0;
`ifdef RUNNER_PAUSE_EN
      pause_q     <= 1'b0;
      paused_r    <= 1'b0;
`endif
    end else begin
      pcnt        <= pcnt_nxt;
      // Registered look-ahead so tick is high exactly while pcnt == TICK_DIV-1.
      tick_r      <= (pcnt_nxt == TICK_LAST);
      btn_q       <= gif.btn_jump;
      st          <= st_nxt;
      jump_y      <= jy_nxt;
      score       <= sc_nxt;
      sub         <= sub_nxt;
      run_en_r    <= is_active(st_nxt) & ~paused_nxt;
      game_over_r <= (st_nxt == S_DEAD);
`ifdef RUNNER_PAUSE_EN
      pause_q     <= gif.btn_pause;
      paused_r    <= paused_nxt;
`endif
    end
  end

  assign gif.tick      = tick_r;
  assign gif.state     = st;
  assign gif.jump_y    = jump_y;
  assign gif.score_bcd = score;
  assign gif.run_en    = run_en_r;
  assign gif.game_over = game_over_r;

endmodule
